// File: rtl/divider_frontend_pkg.sv
// Shared definitions for the divider request frontend.
// Op encodings, FSM states and op-class predicates.
package divider_frontend_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/twos_complement_magnitude.sv
// Splits a two's-complement or unsigned value into sign and magnitude.
// The negation wraps, so the most negative value maps to 0x8..0.
module twos_complement_magnitude #(
  parameter int W = 64
) (
  input  logic [W-1:0] value_i,
  input  logic         signed_en_i,
  output logic         sign_o,
  output logic [W-1:0] magnitude_o
);

  assign sign_o      = signed_en_i & value_i[W-1];
  assign magnitude_o = sign_o ? (-value_i) : value_i;

endmodule

// File: rtl/divider_request_frontend.sv
// Operand preparation and result sign fixup around the SRT divider core.
// Divide-by-zero and signed overflow are answered without the core.
module divider_request_frontend
  import divider_frontend_pkg::*;
#(
  parameter int OPERAND_WIDTH_IN_BITS = 64,
  parameter int TAG_WIDTH_IN_BITS     = 8
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             request_valid_in,
  output logic                             request_ready_out,
  input  logic [1:0]                       request_op_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] request_dividend_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] request_divisor_in,
  input  logic [TAG_WIDTH_IN_BITS-1:0]     request_tag_in,
  output logic                             div_request_valid_out,
  input  logic                             div_request_ack_in,
  output logic                             div_dividend_sign_out,
  output logic                             div_divisor_sign_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] div_dividend_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] div_divisor_out,
  input  logic                             div_result_valid_in,
  output logic                             div_result_ack_out,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] div_quotient_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] div_remainder_in,
  output logic                             result_valid_out,
  input  logic                             result_ready_in,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] result_out,
  output logic [TAG_WIDTH_IN_BITS-1:0]     result_tag_out
);

  localparam int W = OPERAND_WIDTH_IN_BITS;
  localparam int T = TAG_WIDTH_IN_BITS;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES    = {W{1'b1}};

  state_e         state_q;
  logic           ready_q;
  logic           req_valid_q;
  logic           res_ack_q;
  logic           res_valid_q;
  logic           dd_sign_q;
  logic           dv_sign_q;
  logic [W-1:0]   dd_mag_q;
  logic [W-1:0]   dv_mag_q;
  logic           rem_q;
  logic [W-1:0]   result_q;
  logic [T-1:0]   tag_q;

  logic           signed_op;
  logic           rem_op;
  logic           dd_sign_d;
  logic           dv_sign_d;
  logic [W-1:0]   dd_mag_d;
  logic [W-1:0]   dv_mag_d;
  logic           div_zero;
  logic           overflow;
  logic [W-1:0]   special_d;
  logic [W-1:0]   core_mag;
  logic           core_neg;
  logic [W-1:0]   fixup_d;

  assign signed_op = is_signed_op(request_op_in);
  assign rem_op    = is_rem_op(request_op_in);

  twos_complement_magnitude #(.W(W)) u_dividend (
    .value_i     (request_dividend_in),
    .signed_en_i (signed_op),
    .sign_o      (dd_sign_d),
    .magnitude_o (dd_mag_d)
  );

  twos_complement_magnitude #(.W(W)) u_divisor (
    .value_i     (request_divisor_in),
    .signed_en_i (signed_op),
    .sign_o      (dv_sign_d),
    .magnitude_o (dv_mag_d)
  );

  assign div_zero = (request_divisor_in == '0);
  assign overflow = signed_op
                  && (request_dividend_in == MIN_NEG)
                  && (request_divisor_in == ONES);

  always_comb begin
    special_d = rem_op ? '0 : MIN_NEG;
    if (div_zero) begin
      special_d = rem_op ? request_dividend_in : ONES;
    end
  end

  // Latched signs decide the result sign; the core's magnitude is unsigned.
  assign core_mag = rem_q ? div_remainder_in : div_quotient_in;
  assign core_neg = rem_q ? dd_sign_q : (dd_sign_q ^ dv_sign_q);
  assign fixup_d  = core_neg ? (-core_mag) : core_mag;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      req_valid_q <= 1'b0;
      res_ack_q   <= 1'b0;
      res_valid_q <= 1'b0;
      dd_sign_q   <= 1'b0;
      dv_sign_q   <= 1'b0;
      dd_mag_q    <= '0;
      dv_mag_q    <= '0;
      rem_q       <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (request_valid_in && ready_q) begin
            ready_q   <= 1'b0;
            dd_sign_q <= dd_sign_d;
            dv_sign_q <= dv_sign_d;
            dd_mag_q  <= dd_mag_d;
            dv_mag_q  <= dv_mag_d;
            rem_q     <= rem_op;
            tag_q     <= request_tag_in;
            if (div_zero || overflow) begin
              result_q    <= special_d;
              res_valid_q <= 1'b1;
              state_q     <= ST_RESPOND;
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (div_request_ack_in) begin
            req_valid_q <= 1'b0;
            res_ack_q   <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (div_result_valid_in) begin
            result_q    <= fixup_d;
            res_ack_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (result_ready_in) begin
            res_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign request_ready_out     = ready_q;
  assign div_request_valid_out = req_valid_q;
  assign div_dividend_sign_out = dd_sign_q;
  assign div_divisor_sign_out  = dv_sign_q;
  assign div_dividend_out      = dd_mag_q;
  assign div_divisor_out       = dv_mag_q;
  assign div_result_ack_out    = res_ack_q;
  assign result_valid_out      = res_valid_q;
  assign result_out            = result_q;
  assign result_tag_out        = tag_q;

endmodule
